// File: rtl/result_q_pkg.sv
// Shared sizing and types for the per-reservation-station result queues.
package result_q_pkg;
  localparam int unsigned NUM_RS  = 7;
  localparam int unsigned Q_DEPTH = 32;
  localparam int unsigned PTR_W   = $clog2(Q_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned SEL_W   = $clog2(NUM_RS);

  typedef logic [PTR_W-1:0] q_ptr_t;
  typedef logic [CNT_W-1:0] q_cnt_t;
  typedef logic [SEL_W-1:0] q_sel_t;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotate by base, take lowest set bit, rotate back.
module rr_priority_picker #(
  parameter int unsigned N  = 7,
  parameter int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] base,
  output logic [SW-1:0] grant,
  output logic          none
);

  logic [N-1:0]  rot;
  logic [SW-1:0] off;

  // base is always < N, so a single conditional subtract is a full modulo
  function automatic int unsigned wrap_n(input int unsigned v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = req[SW'(wrap_n(i + 32'(base)))];
    end
    none = 1'b1;
    off  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && none) begin
        off  = SW'(i);
        none = 1'b0;
      end
    end
    grant = SW'(wrap_n(32'(off) + 32'(base)));
  end

endmodule

// File: rtl/result_pop_scheduler.sv
// Pointer/occupancy keeper and round-robin pop scheduler for the result queues;
// the BRAMs and output mux live outside and follow wr_addr/rd_addr/out_sel.
module result_pop_scheduler
  import result_q_pkg::*;
#(
  parameter int unsigned NUM_Q = NUM_RS
) (
  input  logic                        clock,
  input  logic                        rstn,
  input  logic                        flash,
  input  logic [NUM_Q-1:0]            push_en,
  output logic [NUM_Q-1:0]            full,
  output logic [NUM_Q-1:0][PTR_W-1:0] wr_addr,
  output q_ptr_t                      rd_addr,
  output logic                        out_en,
  output q_sel_t                      out_sel,
  input  logic                        out_reject
);

  q_ptr_t head_q  [NUM_Q];
  q_ptr_t head_d  [NUM_Q];
  q_ptr_t tail_q  [NUM_Q];
  q_ptr_t tail_d  [NUM_Q];
  q_cnt_t count_q [NUM_Q];
  q_cnt_t count_d [NUM_Q];
  q_sel_t rr_q, rr_d;
  q_sel_t s2_sel_q, s2_sel_d;
  logic   s2_valid_q, s2_valid_d;

  logic [NUM_Q-1:0] elig;
  logic [NUM_Q-1:0] inc_v;
  logic [NUM_Q-1:0] dec_v;
  q_sel_t           pick;
  logic             pick_none;
  logic             pop;
  logic             advance;
  logic             grant;

  rr_priority_picker #(.N(NUM_Q), .SW(SEL_W)) u_picker (
    .req   (elig),
    .base  (rr_q),
    .grant (pick),
    .none  (pick_none)
  );

  always_comb begin
    pop     = s2_valid_q & ~out_reject;
    advance = ~s2_valid_q | ~out_reject;
    grant   = advance & ~pick_none;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      full[i]    = (count_q[i] == q_cnt_t'(Q_DEPTH));
      wr_addr[i] = tail_q[i];
      inc_v[i]   = push_en[i] & ~full[i];
      dec_v[i]   = pop && (s2_sel_q == q_sel_t'(i));
      // the entry sitting in s2 is still counted but must not be granted twice
      elig[i]    = (count_q[i] - q_cnt_t'(s2_valid_q && (s2_sel_q == q_sel_t'(i)))) != '0;
    end
    rd_addr = head_q[s2_sel_q];
    if (grant) begin
      rd_addr = head_q[pick] + q_ptr_t'(s2_valid_q && (s2_sel_q == pick));
    end
    out_en  = s2_valid_q & ~flash;
    out_sel = s2_sel_q;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rr_d       = rr_q;
    s2_sel_d   = s2_sel_q;
    s2_valid_d = s2_valid_q;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      tail_d[i]  = tail_q[i] + q_ptr_t'(inc_v[i]);
      head_d[i]  = head_q[i] + q_ptr_t'(dec_v[i]);
      count_d[i] = count_q[i] + q_cnt_t'(inc_v[i]) - q_cnt_t'(dec_v[i]);
    end
    if (advance) begin
      s2_valid_d = ~pick_none;
      if (!pick_none) begin
        s2_sel_d = pick;
        rr_d     = (pick == q_sel_t'(NUM_Q - 1)) ? '0 : pick + q_sel_t'(1);
      end
    end
    if (flash) begin
      for (int unsigned i = 0; i < NUM_Q; i++) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end
      rr_d       = '0;
      s2_sel_d   = '0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_Q; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rr_q       <= '0;
      s2_sel_q   <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_Q; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
      rr_q       <= rr_d;
      s2_sel_q   <= s2_sel_d;
      s2_valid_q <= s2_valid_d;
    end
  end

endmodule

// File: tb/tb_result_pop_scheduler.sv
// Bench for result_pop_scheduler: queue-of-tags model plus a BRAM stand-in, with directed scenarios.
module tb_result_pop_scheduler;

  logic             clock = 1'b0;
  logic             rstn;
  logic             flash;
  logic [6:0]       push_en;
  logic [6:0]       full;
  logic [6:0][4:0]  wr_addr;
  logic [4:0]       rd_addr;
  logic             out_en;
  logic [2:0]       out_sel;
  logic             out_reject;

  result_pop_scheduler #(.NUM_Q(7)) dut (
    .clock      (clock),
    .rstn       (rstn),
    .flash      (flash),
    .push_en    (push_en),
    .full       (full),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .out_en     (out_en),
    .out_sel    (out_sel),
    .out_reject (out_reject)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // external BRAM stand-in and values sampled away from the clock edge
  int              mem [7][32];
  int              rdata [7];
  logic [6:0]      s_full = '1;
  logic [6:0][4:0] s_wr   = '0;
  logic [4:0]      s_rd   = '0;

  // behavioural model: FIFO of tags per queue plus the one presented entry
  int mq [7][$];
  bit pv = 1'b0;
  int ps = 0;
  int ptag = 0;
  int rr = 0;
  int wcnt [7];
  int cyc = 0;
  bit mfull [7];
  bit found;
  int g;
  int exp_full;

  function automatic int occ(input int i);
    return mq[i].size() + ((pv && ps == i) ? 1 : 0);
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 7; i++) rdata[i] = mem[i][s_rd];
    for (int i = 0; i < 7; i++)
      if (push_en[i] && !s_full[i]) mem[i][s_wr[i]] = cyc * 8 + i;

    if (!rstn || flash) begin
      for (int i = 0; i < 7; i++) begin
        mq[i].delete();
        wcnt[i] = 0;
      end
      pv = 1'b0;
      ps = 0;
      rr = 0;
    end else begin
      for (int i = 0; i < 7; i++) mfull[i] = (occ(i) == 32);
      if (!pv || !out_reject) begin
        found = 1'b0;
        g = 0;
        for (int k = 0; k < 7; k++) begin
          if (!found && mq[(rr + k) % 7].size() > 0) begin
            found = 1'b1;
            g = (rr + k) % 7;
          end
        end
        if (found) begin
          pv   = 1'b1;
          ps   = g;
          ptag = mq[g].pop_front();
          rr   = (g + 1) % 7;
        end else begin
          pv = 1'b0;
        end
      end
      for (int i = 0; i < 7; i++) begin
        if (push_en[i] && !mfull[i]) begin
          mq[i].push_back(cyc * 8 + i);
          wcnt[i] = (wcnt[i] + 1) % 32;
        end
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (cyc > 0) begin
      check("out_en", int'(out_en), int'(pv && !flash));
      if (pv && !flash && out_en) begin
        check("out_sel", int'(out_sel), ps);
        check("data_order", rdata[out_sel], ptag);
      end
      exp_full = 0;
      for (int i = 0; i < 7; i++) if (occ(i) == 32) exp_full |= (1 << i);
      check("full_vec", int'(full), exp_full);
      for (int i = 0; i < 7; i++) check($sformatf("wr_addr%0d", i), int'(wr_addr[i]), wcnt[i]);
    end
    s_full = full;
    s_wr   = wr_addr;
    s_rd   = rd_addr;
  end

  // apply inputs just after an edge and return at the middle of that cycle
  task automatic step(input bit r, input bit f, input logic [6:0] p, input bit rej);
    @(posedge clock);
    #1;
    rstn       = r;
    flash      = f;
    push_en    = p;
    out_reject = rej;
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 7'h00, 1'b0);
  endtask

  int seq3 [6] = '{0, 2, 5, 0, 2, 5};

  initial begin
    rstn       = 1'b0;
    flash      = 1'b0;
    push_en    = 7'h7F;
    out_reject = 1'b0;

    // reset held with every queue offering
    step(1'b0, 1'b0, 7'h7F, 1'b0);
    step(1'b0, 1'b0, 7'h7F, 1'b0);
    step(1'b1, 1'b0, 7'h01, 1'b0);
    check("rst_out_en", int'(out_en), 0);
    check("rst_full", int'(full), 0);
    for (int i = 0; i < 7; i++) check("rst_wr_addr", int'(wr_addr[i]), 0);
    idle(1);
    check("first_push_accepted", int'(wr_addr[0]), 1);
    idle(1);
    check("first_push_out_en", int'(out_en), 1);
    check("first_push_sel", int'(out_sel), 0);
    idle(2);

    // single push on q3
    step(1'b1, 1'b1, 7'h00, 1'b0);
    step(1'b1, 1'b0, 7'h08, 1'b0);
    step(1'b1, 1'b0, 7'h00, 1'b0);
    check("q3_rd_addr_c1", int'(rd_addr), 0);
    check("q3_out_en_c1", int'(out_en), 0);
    idle(1);
    check("q3_out_en_c2", int'(out_en), 1);
    check("q3_sel_c2", int'(out_sel), 3);
    idle(1);
    check("q3_out_en_c3", int'(out_en), 0);
    step(1'b1, 1'b0, 7'h08, 1'b0);
    idle(1);
    check("q3_head_after_pop", int'(rd_addr), 1);
    idle(3);

    // two pushes each on q0, q2, q5
    step(1'b1, 1'b1, 7'h00, 1'b0);
    step(1'b1, 1'b0, 7'h25, 1'b0);
    step(1'b1, 1'b0, 7'h25, 1'b0);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      check("rr_seq_en", int'(out_en), 1);
      check("rr_seq_sel", int'(out_sel), seq3[k]);
    end
    idle(1);
    check("rr_seq_done", int'(out_en), 0);
    idle(2);

    // stall on q2 for three cycles
    step(1'b1, 1'b1, 7'h00, 1'b0);
    step(1'b1, 1'b0, 7'h24, 1'b0);
    step(1'b1, 1'b0, 7'h24, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 7'h00, 1'b1);
      check("stall_en", int'(out_en), 1);
      check("stall_sel", int'(out_sel), 2);
      check("stall_rd_addr", int'(rd_addr), 0);
    end
    idle(1);
    check("release_sel", int'(out_sel), 2);
    idle(1);
    check("after_release_sel", int'(out_sel), 5);
    idle(1);
    check("after_release_sel2", int'(out_sel), 2);
    idle(1);
    check("after_release_sel3", int'(out_sel), 5);
    idle(1);
    check("after_release_empty", int'(out_en), 0);
    idle(2);

    // fill q1 while stalled
    step(1'b1, 1'b1, 7'h00, 1'b0);
    for (int k = 0; k < 32; k++) step(1'b1, 1'b0, 7'h02, 1'b1);
    step(1'b1, 1'b0, 7'h02, 1'b1);
    check("q1_full", int'(full[1]), 1);
    step(1'b1, 1'b0, 7'h00, 1'b1);
    check("q1_33rd_rejected", int'(wr_addr[1]), 0);
    check("q1_still_full", int'(full[1]), 1);
    step(1'b1, 1'b0, 7'h00, 1'b0);
    step(1'b1, 1'b0, 7'h00, 1'b1);
    check("q1_not_full", int'(full[1]), 0);
    idle(40);
    check("q1_drained", int'(out_en), 0);

    // streaming push/pop on q4 across the pointer wrap
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 7'h10, 1'b0);
    idle(4);
    check("q4_drained", int'(out_en), 0);

    // flush while stalled with four queues occupied
    step(1'b1, 1'b0, 7'h0F, 1'b1);
    step(1'b1, 1'b0, 7'h0F, 1'b1);
    step(1'b1, 1'b0, 7'h00, 1'b1);
    step(1'b1, 1'b0, 7'h00, 1'b1);
    check("pre_flash_en", int'(out_en), 1);
    step(1'b1, 1'b1, 7'h00, 1'b1);
    check("flash_out_en", int'(out_en), 0);
    step(1'b1, 1'b0, 7'h40, 1'b0);
    check("post_flash_full", int'(full), 0);
    check("post_flash_en", int'(out_en), 0);
    idle(1);
    check("q6_not_yet", int'(out_en), 0);
    idle(1);
    check("q6_out_en", int'(out_en), 1);
    check("q6_sel", int'(out_sel), 6);
    idle(1);
    check("flushed_empty", int'(out_en), 0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
